// File: rtl/halt_monitor.sv
// Halt monitor: stops the core on a run of NOPs, a misaligned fetch PC or (HALT_CYCLE_LIMIT_EN) a cycle budget.
// Latency: w_halt/w_cause/w_halt_pc register one clock after the offending issue cycle; w_led is decoded from registers.
// Backpressure: none; observes the issue stream only and never stalls it.
module halt_monitor #(
   parameter int unsigned NOP_LIMIT   = 6,
   parameter int unsigned CYCLE_LIMIT = 10000000
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        w_valid,
   input  logic [31:0] w_pc,
   input  logic [31:0] w_ir,
   output logic        w_halt,
   output logic [1:0]  w_cause,
   output logic [31:0] w_cycle,
   output logic [31:0] w_halt_pc,
   output logic [15:0] w_led
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_NOP   = 2'd1;
   localparam logic [1:0] CAUSE_ALIGN = 2'd2;
   localparam logic [1:0] CAUSE_LIMIT = 2'd3;
   localparam logic [7:0] NOP_MAX     = NOP_LIMIT[7:0];

`ifdef HALT_CYCLE_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [7:0]  nop_q, nop_d;
   logic [31:0] cycle_q, cycle_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] hpc_q, hpc_d;

   logic        active;
   logic        is_nop;
   logic [7:0]  nop_inc;
   logic [31:0] cycle_inc;
   logic        ev_align, ev_nop, ev_limit;

   always_comb begin
      state_d   = state_q;
      nop_d     = nop_q;
      cycle_d   = cycle_q;
      cause_d   = cause_q;
      hpc_d     = hpc_q;

      // The first valid issue in IDLE already counts as a RUN cycle.
      active    = (state_q == RUN) || ((state_q == IDLE) && w_valid);
      is_nop    = w_valid && (w_ir == 32'd0);
      nop_inc   = (nop_q >= NOP_MAX) ? NOP_MAX : nop_q + 8'd1;
      cycle_inc = (&cycle_q) ? cycle_q : cycle_q + 32'd1;

      ev_align  = w_valid && (w_pc[1:0] != 2'b00);
      ev_nop    = is_nop && (nop_q < NOP_MAX) && (nop_inc == NOP_MAX);
      // Judged on the value being written so the counter freezes at CYCLE_LIMIT+1.
      ev_limit  = LIMIT_EN && (cycle_inc > CYCLE_LIMIT);

      if (active) begin
         state_d = RUN;
         cycle_d = cycle_inc;
         if (w_valid) begin
            nop_d = is_nop ? nop_inc : 8'd0;
         end
         if (ev_align || ev_nop || ev_limit) begin
            state_d = HALTED;
            hpc_d   = w_pc;
            if (ev_align) begin
               cause_d = CAUSE_ALIGN;
            end else if (ev_nop) begin
               cause_d = CAUSE_NOP;
            end else begin
               cause_d = CAUSE_LIMIT;
            end
         end
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= IDLE;
         nop_q   <= 8'd0;
         cycle_q <= 32'd0;
         cause_q <= 2'd0;
         hpc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         nop_q   <= nop_d;
         cycle_q <= cycle_d;
         cause_q <= cause_d;
         hpc_q   <= hpc_d;
      end
   end

   assign w_halt    = (state_q == HALTED);
   assign w_cause   = cause_q;
   assign w_cycle   = cycle_q;
   assign w_halt_pc = hpc_q;
   assign w_led     = w_halt ? {cause_q, hpc_q[15:2]} : {2'b00, cycle_q[23:10]};

endmodule

// File: tb/tb_halt_monitor.sv
// Bench for halt_monitor: directed scenarios with literal expectations plus randomized episodes
// checked every cycle against a history-based reference model.
module tb_halt_monitor;

   localparam int unsigned NL = 6;
   localparam int unsigned CL = 20;

   logic        w_clk   = 1'b0;
   logic        w_rst_n = 1'b1;
   logic        w_valid = 1'b0;
   logic [31:0] w_pc    = 32'd0;
   logic [31:0] w_ir    = 32'd0;
   logic        w_halt;
   logic [1:0]  w_cause;
   logic [31:0] w_cycle;
   logic [31:0] w_halt_pc;
   logic [15:0] w_led;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   halt_monitor #(.NOP_LIMIT(NL), .CYCLE_LIMIT(CL)) dut (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .w_valid   (w_valid),
      .w_pc      (w_pc),
      .w_ir      (w_ir),
      .w_halt    (w_halt),
      .w_cause   (w_cause),
      .w_cycle   (w_cycle),
      .w_halt_pc (w_halt_pc),
      .w_led     (w_led)
   );

   always #5 w_clk = ~w_clk;

   // Reference model: keeps the whole issued-instruction history since reset and
   // derives the NOP run as the number of trailing zero words in it.
   bit          m_run, m_halt;
   logic [1:0]  m_cause;
   logic [31:0] m_cycle, m_hpc;
   logic [31:0] hist[$];
   int          tz;
   bit          e_align, e_nop, e_lim;

   always @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         m_run = 0; m_halt = 0; m_cause = 0; m_cycle = 0; m_hpc = 0;
         hist.delete();
      end else if (!m_halt && (m_run || w_valid)) begin
         m_run = 1;
         if (m_cycle != 32'hFFFFFFFF) m_cycle = m_cycle + 1;
         if (w_valid) hist.push_back(w_ir);
         tz = 0;
         for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != 0) break;
            tz++;
         end
         e_align = w_valid && (w_pc % 4 != 0);
         e_nop   = w_valid && (w_ir == 0) && (tz == NL);
`ifdef HALT_CYCLE_LIMIT_EN
         e_lim   = (m_cycle > CL);
`else
         e_lim   = 0;
`endif
         if (e_align || e_nop || e_lim) begin
            m_halt  = 1;
            m_hpc   = w_pc;
            m_cause = e_align ? 2'd2 : (e_nop ? 2'd1 : 2'd3);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge w_clk) begin
      if (chk_en) begin
         chk("halt",    32'(w_halt),  32'(m_halt));
         chk("cause",   32'(w_cause), 32'(m_cause));
         chk("cycle",   w_cycle,      m_cycle);
         chk("halt_pc", w_halt_pc,    m_hpc);
         chk("led",     32'(w_led),
             m_halt ? 32'({m_cause, m_hpc[15:2]}) : 32'({2'b00, m_cycle[23:10]}));
      end
   end

   task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ir);
      w_valid = v;
      w_pc    = pc;
      w_ir    = ir;
      @(negedge w_clk);
   endtask

   // Reset pulse placed between clock edges; optionally checks outputs clear at once.
   task automatic do_reset(input bit lit);
      w_valid = 0;
      #2 w_rst_n = 0;
      #1;
      if (lit) begin
         chk("rst_halt",  32'(w_halt),  32'd0);
         chk("rst_cause", 32'(w_cause), 32'd0);
         chk("rst_cycle", w_cycle,      32'd0);
         chk("rst_hpc",   w_halt_pc,    32'd0);
         chk("rst_led",   32'(w_led),   32'd0);
      end
      #1 w_rst_n = 1;
      @(negedge w_clk);
   endtask

   initial begin
      #2 w_rst_n = 0;
      #1;
      chk("init_halt",  32'(w_halt),  32'd0);
      chk("init_cycle", w_cycle,      32'd0);
      chk("init_led",   32'(w_led),   32'd0);
      @(negedge w_clk);
      w_rst_n = 1;
      chk_en  = 1;
      step(0, 32'h0, 32'h0);
      chk("idle_cycle", w_cycle, 32'd0);

      // Six NOPs at 0x10..0x24 halt with cause 1.
      for (int i = 0; i < 6; i++) begin
         step(1, 32'h10 + 4 * i, 32'h0);
         if (i == 4) chk("nop5_nohalt", 32'(w_halt), 32'd0);
      end
      chk("nop6_halt",  32'(w_halt), 32'd1);
      chk("nop6_cause", 32'(w_cause), 32'd1);
      chk("nop6_hpc",   w_halt_pc, 32'h24);
      chk("nop6_cycle", w_cycle, 32'd6);
      chk("nop6_led",   32'(w_led), 32'h4009);
      step(1, 32'h3, 32'h55);
      step(1, 32'h40, 32'h0);
      chk("frozen_cycle", w_cycle, 32'd6);
      chk("frozen_hpc",   w_halt_pc, 32'h24);

      // A nonzero instruction breaks the run; invalid cycles do not.
      do_reset(0);
      for (int i = 0; i < 11; i++) step(1, 32'h100 + 4 * i, (i == 5) ? 32'h13 : 32'h0);
      chk("broken_run", 32'(w_halt), 32'd0);
      do_reset(0);
      for (int i = 0; i < 5; i++) step(1, 32'h200 + 4 * i, 32'h0);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0);
      chk("gap_nohalt", 32'(w_halt), 32'd0);
      step(1, 32'h214, 32'h0);
      chk("gap_halt",  32'(w_halt), 32'd1);
      chk("gap_cause", 32'(w_cause), 32'd1);

      // Misaligned PC coinciding with the sixth NOP wins.
      do_reset(0);
      for (int i = 0; i < 5; i++) step(1, 32'h10 + 4 * i, 32'h0);
      step(1, 32'h102, 32'h0);
      chk("mis_cause", 32'(w_cause), 32'd2);
      chk("mis_hpc",   w_halt_pc, 32'h102);
      chk("mis_led",   32'(w_led), 32'h8040);

      // Asynchronous reset while halted, then wait in IDLE.
      do_reset(1);
      for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0);
      chk("wait_cycle", w_cycle, 32'd0);
      chk("wait_halt",  32'(w_halt), 32'd0);
      step(1, 32'h400, 32'h13);
      chk("first_cycle", w_cycle, 32'd1);

      // Cycle budget with nonzero instructions every cycle.
      do_reset(0);
      for (int i = 0; i < 25; i++) step(1, 32'h1000 + 4 * i, 32'h13);
`ifdef HALT_CYCLE_LIMIT_EN
      chk("lim_halt",  32'(w_halt), 32'd1);
      chk("lim_cause", 32'(w_cause), 32'd3);
      chk("lim_cycle", w_cycle, 32'd21);
`else
      chk("lim_nohalt", 32'(w_halt), 32'd0);
      chk("lim_cycle",  w_cycle, 32'd25);
`endif

      // Randomized episodes, each from a fresh reset.
      for (int ep = 0; ep < 40; ep++) begin
         int len;
         logic [31:0] base;
         do_reset(ep % 8 == 0);
         len  = $urandom_range(5, 40);
         base = {$urandom_range(0, 16'hFFFF), 16'h0};
         for (int i = 0; i < len; i++) begin
            bit v;
            logic [31:0] pc, ir;
            v  = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 9) < 6) ? 32'h0 : ($urandom | 32'h1);
            pc = base + 4 * i;
            if ((ep % 2 == 1) && ($urandom_range(0, 24) == 0)) pc = pc | $urandom_range(1, 3);
            step(v, pc, ir);
         end
      end

      chk_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/halt_monitor.md
HALT_MONITOR -- requirements
Module: halt_monitor

Interface
REQ-001 The module SHALL have parameter NOP_LIMIT, default 6, giving the consecutive-NOP count that halts the core.
REQ-002 The module SHALL have parameter CYCLE_LIMIT, default 10000000, giving the run-cycle count beyond which the core halts.
REQ-003 The module SHALL have port w_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port w_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port w_valid, input, 1 bit: w_pc and w_ir describe the instruction issued this cycle.
REQ-006 The module SHALL have port w_pc, input, 32 bits: fetch PC of the issued instruction.
REQ-007 The module SHALL have port w_ir, input, 32 bits: issued instruction word.
REQ-008 The module SHALL have port w_halt, output, 1 bit: core must stop; level, sticky until reset.
REQ-009 The module SHALL have port w_cause, output, 2 bits: 0 none, 1 NOP run, 2 misaligned PC, 3 cycle limit.
REQ-010 The module SHALL have port w_cycle, output, 32 bits: run-cycle counter, frozen once halted.
REQ-011 The module SHALL have port w_halt_pc, output, 32 bits: w_pc captured on the halting event.
REQ-012 The module SHALL have port w_led, output, 16 bits: {w_cause, w_halt_pc[15:2]} when halted, else {2'b00, w_cycle[23:10]}.

Function
REQ-013 The module SHALL implement FSM states IDLE, RUN and HALTED, entering IDLE on reset.
REQ-014 IDLE SHALL move to RUN on the first cycle with w_valid=1; that cycle is evaluated as a RUN cycle.
REQ-015 In RUN, w_cycle SHALL increment by 1 every clock, saturating at 32'hFFFFFFFF.
REQ-016 In RUN, the 8-bit NOP counter SHALL increment on w_valid && w_ir==0, clear on w_valid && w_ir!=0, hold when w_valid=0, and saturate at NOP_LIMIT.
REQ-017 The NOP event SHALL fire on the cycle the incoming NOP makes the counter equal NOP_LIMIT.
REQ-018 The misaligned event SHALL fire on w_valid && w_pc[1:0]!=2'b00.
REQ-019 The cycle-limit event SHALL fire when w_cycle > CYCLE_LIMIT.
REQ-020 On any event, the FSM SHALL enter HALTED on the next edge; w_halt, w_cause and w_halt_pc are registered outputs (one-cycle latency).
REQ-021 On simultaneous events, cause priority SHALL be misaligned (2) > NOP (1) > cycle limit (3).
REQ-022 HALTED SHALL be terminal: all inputs ignored, outputs frozen, until w_rst_n is asserted.
REQ-023 In IDLE, w_cycle and the NOP counter SHALL hold at 0.

Reset
REQ-024 On w_rst_n=0, regardless of clock, the state SHALL be IDLE and w_halt=0, w_cause=0, w_cycle=0, w_halt_pc=0, NOP counter=0, w_led=0.
REQ-025 Reset asserted mid-RUN or in HALTED SHALL discard all progress; after deassertion the block waits in IDLE for w_valid.

Configuration
REQ-026 Macro HALT_CYCLE_LIMIT_EN defined: the cycle-limit event (REQ-019) SHALL be active.
REQ-027 Macro HALT_CYCLE_LIMIT_EN undefined: the cycle-limit event SHALL never fire, cause 3 is never produced, and w_cycle still counts and saturates.

Verification
REQ-028 Bench: reset, then 6 consecutive valid w_ir=0 at pc 0x10..0x24 -> w_halt=1 one cycle after the 6th, w_cause=1, w_halt_pc=0x24.
REQ-029 Bench: 5 NOPs, one valid nonzero ir, 5 NOPs -> no halt; 5 NOPs, w_valid=0 for 3 cycles, 1 NOP -> halt with cause 1.
REQ-030 Bench: valid w_pc=0x00000102 on the same cycle as the 6th NOP -> w_cause=2, w_halt_pc=0x102.
REQ-031 Bench: with HALT_CYCLE_LIMIT_EN and CYCLE_LIMIT=20, nonzero instructions every cycle -> halt with w_cause=3 and w_cycle frozen at 21; without the macro -> no halt.
REQ-032 Bench: w_rst_n pulsed low between clock edges while HALTED -> outputs 0 immediately; w_cycle stays 0 until the first w_valid.
